biquad_mac_sequencer: RTL

Control-side initiator for the shared `MULT_ACC` multiply-accumulator in the audio EQ datapath. It runs one direct-form-I biquad section per input sample: y = b0·x0 + b1·x1 + b2·x2 − a1·y1 − a2·y2. It owns the x/y delay line and the coefficient latch. It drives the MAC's data and control inputs tap by tap, then scales and saturates the accumulator result into an output sample with a one-cycle valid strobe.

---
 rtl/biquad_mac_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/biquad_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : biquad_mac_sequencer
// Description : Direct-form-I biquad sequencer driving a shared external MAC.
//               Owns the x/y delay line and coefficient latch, and scales and
//               saturates the accumulator into the output sample.
// Revision    : 1.0 - initial release
// ============================================================================
module biquad_mac_sequencer #(
    parameter int WIN  = 24,
    parameter int WC   = 18,
    parameter int FRAC = 16,
    parameter int WOUT = 48
) (
    input  logic                   ic_clk,
    input  logic                   ic_rst,
    input  logic signed [WIN-1:0]  id_din,
    input  logic                   ic_valid,
    output logic                   oc_ready,
    input  logic signed [WC-1:0]   id_b0,
    input  logic signed [WC-1:0]   id_b1,
    input  logic signed [WC-1:0]   id_b2,
    input  logic signed [WC-1:0]   id_a1,
    input  logic signed [WC-1:0]   id_a2,
    input  logic                   ic_flush,
    output logic signed [WIN-1:0]  od_mac_din,
    output logic signed [WC-1:0]   od_mac_coef,
    output logic                   oc_mac_ce,
    output logic                   oc_mac_rst,
    output logic                   oc_mac_neg_acc,
    input  logic [WOUT-1:0]        id_mac_dout,
    output logic signed [WIN-1:0]  od_dout,
    output logic                   oc_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_MAC  = 2'd2,
        S_CAP  = 2'd3
    } state_t;

    localparam logic signed [WIN-1:0] c_y_max = {1'b0, {(WIN-1){1'b1}}};
    localparam logic signed [WIN-1:0] c_y_min = {1'b1, {(WIN-1){1'b0}}};
    localparam logic [2:0]            c_last_tap = 3'd4;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [2:0]             r_tap;
    logic                   r_ready;

    logic signed [WIN-1:0]  r_x0, r_x1, r_x2, r_y1, r_y2;
    logic signed [WC-1:0]   r_b0, r_b1, r_b2, r_a1, r_a2;
    logic signed [WIN-1:0]  r_dout;
    logic                   r_valid;

    logic                   w_accept;
    logic                   w_mac_rst;
    logic                   w_mac_ce;
    logic                   w_mac_neg;
    logic signed [WIN-1:0]  w_mac_din;
    logic signed [WC-1:0]   w_mac_coef;

    logic signed [WOUT-1:0] w_shifted;
    logic [WOUT-WIN:0]      w_hi;
    logic signed [WIN-1:0]  w_y;

    // Scale the accumulator back to sample units, clamping to the sample range
    assign w_shifted = $signed(id_mac_dout) >>> FRAC;
    assign w_hi      = w_shifted[WOUT-1:WIN-1];
    assign w_y       = ((&w_hi) || !(|w_hi)) ? w_shifted[WIN-1:0]
                     : (w_hi[WOUT-WIN] ? c_y_min : c_y_max);

    always_ff @(posedge ic_clk) begin
        if (ic_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_mac_rst   = 1'b0;
        w_mac_ce    = 1'b0;
        w_mac_neg   = 1'b0;
        w_mac_din   = '0;
        w_mac_coef  = '0;
        case (r_state)
            S_IDLE: begin
                if (r_ready && ic_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                w_mac_rst   = 1'b1;
                w_state_nxt = S_MAC;
            end
            S_MAC: begin
                w_mac_ce = 1'b1;
                case (r_tap)
                    3'd0: begin
                        w_mac_din  = r_x0;
                        w_mac_coef = r_b0;
                    end
                    3'd1: begin
                        w_mac_din  = r_x1;
                        w_mac_coef = r_b1;
                    end
                    3'd2: begin
                        w_mac_din  = r_x2;
                        w_mac_coef = r_b2;
                    end
                    3'd3: begin
                        w_mac_din  = r_y1;
                        w_mac_coef = r_a1;
                        w_mac_neg  = 1'b1;
                    end
                    default: begin
                        w_mac_din  = r_y2;
                        w_mac_coef = r_a2;
                        w_mac_neg  = 1'b1;
                    end
                endcase
                if (r_tap == c_last_tap) begin
                    w_state_nxt = S_CAP;
                end
            end
            S_CAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Reset and flush abort everything and hold the MAC cleared
        if (ic_rst || ic_flush) begin
            w_state_nxt = S_IDLE;
            w_accept    = 1'b0;
            w_mac_rst   = 1'b1;
            w_mac_ce    = 1'b0;
            w_mac_neg   = 1'b0;
            w_mac_din   = '0;
            w_mac_coef  = '0;
        end
    end

    always_ff @(posedge ic_clk) begin
        if (ic_rst) begin
            r_tap   <= '0;
            r_ready <= 1'b0;
            r_x0    <= '0;
            r_x1    <= '0;
            r_x2    <= '0;
            r_y1    <= '0;
            r_y2    <= '0;
            r_b0    <= '0;
            r_b1    <= '0;
            r_b2    <= '0;
            r_a1    <= '0;
            r_a2    <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt == S_IDLE);
            r_valid <= 1'b0;
            if (r_state == S_MAC && !ic_flush) begin
                r_tap <= r_tap + 3'd1;
            end else begin
                r_tap <= '0;
            end
            if (ic_flush) begin
                r_x1 <= '0;
                r_x2 <= '0;
                r_y1 <= '0;
                r_y2 <= '0;
            end else begin
                if (w_accept) begin
                    r_x0 <= id_din;
                    r_b0 <= id_b0;
                    r_b1 <= id_b1;
                    r_b2 <= id_b2;
                    r_a1 <= id_a1;
                    r_a2 <= id_a2;
                end
                // Feedback history keeps the saturated sample, not the raw sum
                if (r_state == S_CAP) begin
                    r_dout  <= w_y;
                    r_valid <= 1'b1;
                    r_x2    <= r_x1;
                    r_x1    <= r_x0;
                    r_y2    <= r_y1;
                    r_y1    <= w_y;
                end
            end
        end
    end

    assign oc_ready       = r_ready;
    assign oc_mac_rst     = w_mac_rst;
    assign oc_mac_ce      = w_mac_ce;
    assign oc_mac_neg_acc = w_mac_neg;
    assign od_mac_din     = w_mac_din;
    assign od_mac_coef    = w_mac_coef;
    assign od_dout        = r_dout;
    assign oc_valid       = r_valid;

endmodule
`default_nettype wire
